// File: rtl/axis_pkt_mux.sv
// axis_pkt_mux: packet-locked N:1 AXI-Stream multiplexer with a one-beat output register.
// Define AXIS_PKT_MUX_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module axis_pkt_mux #(
  parameter int  DATA_WIDTH  = 8,
  parameter int  NUM_STREAMS = 2,
  localparam int ID_WIDTH    = $clog2(NUM_STREAMS)
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_STREAMS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_STREAMS-1:0]            s_tvalid,
  input  logic [NUM_STREAMS-1:0]            s_tlast,
  output logic [NUM_STREAMS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic [ID_WIDTH-1:0]               m_tid,
  input  logic                              m_tready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg, state_next;
  logic [ID_WIDTH-1:0]   grant_reg, grant_next;
  logic [ID_WIDTH-1:0]   sel;
  logic                  out_free;
  logic                  accept;
  logic                  accept_last;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg;
  logic                  tlast_reg;
  logic [ID_WIDTH-1:0]   tid_reg;
  logic [DATA_WIDTH-1:0] s_words [NUM_STREAMS];

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free    = !tvalid_reg || m_tready;
  assign accept      = |(s_tvalid & s_tready);
  assign accept_last = accept && s_tlast[grant_reg];

  generate
    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
      assign s_words[gi]  = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign s_tready[gi] = (state_reg == BUSY) && (grant_reg == ID_WIDTH'(gi)) && out_free;
    end
  endgenerate

`ifdef AXIS_PKT_MUX_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] ptr_reg, ptr_next;

  // First requester at or after the pointer, wrapping around.
  always_comb begin : arb_rr
    int   idx;
    logic found;
    sel   = ptr_reg;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_STREAMS) idx = idx - NUM_STREAMS;
      if (!found && s_tvalid[ID_WIDTH'(idx)]) begin
        found = 1'b1;
        sel   = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (accept_last) begin
      ptr_next = (grant_reg == ID_WIDTH'(NUM_STREAMS-1)) ? '0 : grant_reg + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ptr_reg <= '0;
    else          ptr_reg <= ptr_next;
  end
`else
  always_comb begin : arb_fixed
    sel = '0;
    for (int i = NUM_STREAMS-1; i >= 0; i--) begin
      if (s_tvalid[ID_WIDTH'(i)]) sel = ID_WIDTH'(i);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (|s_tvalid) begin
          state_next = BUSY;
          grant_next = sel;
        end
      end
      BUSY: begin
        // Grant stays locked until the tlast beat is taken.
        if (accept_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tid_reg    <= '0;
    end else if (accept) begin
      tdata_reg  <= s_words[grant_reg];
      tlast_reg  <= s_tlast[grant_reg];
      tid_reg    <= grant_reg;
      tvalid_reg <= 1'b1;
    end else if (m_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  assign m_tdata  = tdata_reg;
  assign m_tvalid = tvalid_reg;
  assign m_tlast  = tlast_reg;
  assign m_tid    = tid_reg;

endmodule

// File: tb/tb_axis_pkt_mux.sv
// Self-checking bench for axis_pkt_mux: directed scenarios plus randomized traffic
// against per-stream scoreboards and a packet-level arbitration model.
module tb_axis_pkt_mux;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int IW = $clog2(NS);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             m_tready;

  axis_pkt_mux #(.DATA_WIDTH(DW), .NUM_STREAMS(NS)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast (m_tlast),
    .m_tid   (m_tid),
    .m_tready(m_tready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  beat_t src_q [NS][$];
  beat_t exp_q [NS][$];
  int    cyc = 0;
  logic [NS-1:0] hs = '0;
  int    rmode = 1;      // 0 random ready, 1 ready high, 2 ready low
  int    vmode = 0;      // 0 valid whenever data is pending, 1 random gaps
  bit    arb_chk, gap_chk, contig_chk, lat_chk;
  int    ptr = 0;
  bit    in_pkt = 0;
  int    cur_tid = 0;
  int    last_end_cyc = -1;
  int    prev_beat_cyc = 0;
  int    rise_cyc [NS];
  int    in_acc [NS];
  int    out_beats = 0;
  int    stall_cnt = 0;
  bit    prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [IW-1:0] prev_tid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NS; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Packet-level arbitration model; valid only while every stream with queued packets keeps tvalid high.
  function automatic int model_pick();
`ifdef AXIS_PKT_MUX_ROUND_ROBIN_EN
    for (int k = 0; k < NS; k++) if (exp_q[(ptr + k) % NS].size() != 0) return (ptr + k) % NS;
`else
    for (int k = 0; k < NS; k++) if (exp_q[k].size() != 0) return k;
`endif
    return -1;
  endfunction

  task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[s].push_back(b);
    exp_q[s].push_back(b);
  endtask

  task automatic load_rand_pkt(input int s, input int len);
    for (int k = 0; k < len; k++) push_beat(s, DW'($urandom), k == len - 1);
  endtask

  task automatic set_test(input bit arb, input bit gap, input bit contig, input bit lat,
                          input int vm, input int rm);
    arb_chk = arb; gap_chk = gap; contig_chk = contig; lat_chk = lat;
    vmode = vm; rmode = rm;
    last_end_cyc = -1; out_beats = 0; stall_cnt = 0;
    for (int i = 0; i < NS; i++) in_acc[i] = 0;
  endtask

  task automatic sample();
    int    tid;
    beat_t b;
    hs = s_tvalid & s_tready;
    check("tready_onehot", 32'($countones(s_tready) <= 1), 1);
    if (prev_stall) begin
      check("stall_tvalid", m_tvalid, 1);
      check("stall_tdata", m_tdata, prev_data);
      check("stall_tid", m_tid, prev_tid);
      check("stall_tlast", m_tlast, prev_last);
    end
    if (m_tvalid && !m_tready) begin
      stall_cnt++;
      check("stall_s_tready", s_tready, 0);
    end
    if (m_tvalid && m_tready) begin
      tid = int'(m_tid);
      $display("beat cyc=%0d tid=%0d data=0x%02h last=%0b", cyc, tid, m_tdata, m_tlast);
      if (in_pkt) begin
        check("no_interleave", tid, cur_tid);
        if (contig_chk) check("contig_beats", cyc - prev_beat_cyc, 1);
      end else begin
        if (arb_chk) check("arb_pick", tid, model_pick());
        if (gap_chk && last_end_cyc >= 0) check("bubble_gap", cyc - last_end_cyc, 2);
        if (lat_chk) check("latency", cyc - rise_cyc[tid], 2);
      end
      check("beat_expected", exp_q[tid].size() != 0, 1);
      if (exp_q[tid].size() != 0) begin
        b = exp_q[tid].pop_front();
        check("tdata", m_tdata, b.data);
        check("tlast", m_tlast, b.last);
      end
      prev_beat_cyc = cyc;
      out_beats++;
      if (m_tlast) begin
        in_pkt = 0;
        last_end_cyc = cyc;
        ptr = (tid + 1) % NS;
      end else begin
        in_pkt = 1;
        cur_tid = tid;
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data = m_tdata;
    prev_last = m_tlast;
    prev_tid = m_tid;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        in_acc[i]++;
      end
      if (!(s_tvalid[i] && !hs[i])) begin
        if (src_q[i].size() != 0 && (vmode == 0 || $urandom_range(0, 3) != 0)) begin
          if (!s_tvalid[i]) rise_cyc[i] = cyc;
          s_tvalid[i] = 1'b1;
          s_tdata[i*DW +: DW] = src_q[i][0].data;
          s_tlast[i] = src_q[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
    end
    case (rmode)
      0:       m_tready = ($urandom_range(0, 3) != 0);
      1:       m_tready = 1'b1;
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic cycle();
    @(negedge aclk);
    sample();
    @(posedge aclk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (pending() != 0 && n < max) begin
      cycle();
      n++;
    end
    check("drain_pending", pending(), 0);
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_m_tid"}, m_tid, 0);
  endtask

  task automatic reset_pulse();
    @(negedge aclk);
    #1;
    aresetn = 1'b0;
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; hs = '0;
    in_pkt = 0; ptr = 0; prev_stall = 0; last_end_cyc = -1;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge aclk);
    #2;
    aresetn = 1'b1;
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("rst_init");
    #2;
    aresetn = 1'b1;

    // Stream 0: three-beat packet, output always ready.
    set_test(1, 1, 1, 1, 0, 1);
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    drain(50);
    check("pkt3_beats", out_beats, 3);

    // Streams 0 and 1 contend continuously with two-beat packets.
    set_test(1, 1, 1, 0, 0, 1);
    for (int p = 0; p < 3; p++) begin
      load_rand_pkt(0, 2);
      load_rand_pkt(1, 2);
    end
    drain(100);
    check("contend_beats", out_beats, 12);

    // Stream 1 with three stalled cycles mid-packet.
    set_test(1, 0, 0, 0, 0, 1);
    load_rand_pkt(1, 4);
    n = 0;
    while (out_beats < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("stall_setup_beats", out_beats, 2);
    rmode = 2;
    repeat (3) cycle();
    rmode = 1;
    drain(50);
    check("stall_cycles", stall_cnt, 3);
    check("stall_beats", out_beats, 4);

    // Stream 3 alone, then streams 0 and 2 together.
    set_test(1, 0, 0, 0, 0, 1);
    load_rand_pkt(3, 2);
    drain(50);
    load_rand_pkt(0, 2);
    load_rand_pkt(2, 2);
    drain(50);
    check("wrap_beats", out_beats, 6);

    // Reset in the middle of a four-beat packet, then a fresh packet from stream 1.
    set_test(1, 0, 0, 0, 0, 1);
    load_rand_pkt(2, 4);
    n = 0;
    while (in_acc[2] < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("pre_reset_accepts", in_acc[2], 2);
    reset_pulse();
    set_test(1, 0, 0, 1, 0, 1);
    load_rand_pkt(1, 3);
    drain(50);
    check("post_reset_beats", out_beats, 3);

    // Randomized traffic on all streams with random gaps and backpressure.
    set_test(0, 0, 0, 0, 1, 0);
    n = 0;
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < 6; p++) begin
        int len;
        len = int'($urandom_range(1, 5));
        n += len;
        load_rand_pkt(s, len);
      end
    end
    drain(5000);
    check("random_beats", out_beats, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pkt_mux.md
AXIS_PKT_MUX -- requirements
Module: axis_pkt_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 8: tdata width per stream; legal range 1..512.
REQ-002 Parameter NUM_STREAMS, default 2: number of slave streams; legal range 2..16.
REQ-003 Derived localparam ID_WIDTH = clog2(NUM_STREAMS): width of the m_tid field.
REQ-004 Port list, one port per line (name, direction, width, meaning):
- aclk  input  1  sole clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- s_tdata  input  NUM_STREAMS*DATA_WIDTH  flattened slave data; stream i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  NUM_STREAMS  per-stream valid.
- s_tlast  input  NUM_STREAMS  per-stream end-of-packet.
- s_tready  output  NUM_STREAMS  per-stream ready.
- m_tdata  output  DATA_WIDTH  muxed data.
- m_tvalid  output  1  master valid.
- m_tlast  output  1  master end-of-packet.
- m_tid  output  ID_WIDTH  index of the source stream for the current beat.
- m_tready  input  1  master ready.

Function
REQ-005 FSM states: IDLE (no grant) and BUSY (one stream granted and locked).
REQ-006 IDLE: if any s_tvalid bit is high, the arbiter registers grant = selected index and the FSM enters BUSY on the next edge; otherwise it stays in IDLE.
REQ-007 In IDLE, all s_tready bits are 0.
REQ-008 In BUSY, s_tready[grant] = !m_tvalid || m_tready; all other s_tready bits are 0.
REQ-009 A beat is accepted when s_tvalid[grant] && s_tready[grant] are both high.
REQ-010 On acceptance, the output register loads m_tdata, m_tlast and m_tid = grant, and sets m_tvalid on the same edge; input-to-output latency is 1 cycle.
REQ-011 m_tvalid clears on the edge where m_tvalid && m_tready hold and no new beat is accepted.
REQ-012 While m_tvalid && !m_tready, m_tdata, m_tlast and m_tid are held stable.
REQ-013 Simultaneous output drain and input acceptance in one cycle yields full throughput: one beat per cycle.
REQ-014 Acceptance of a beat with s_tlast[grant]=1 returns the FSM to IDLE on the same edge; this gives exactly one arbitration bubble cycle between packets.
REQ-015 The grant is never changed mid-packet, regardless of tvalid activity on other streams.
REQ-016 s_tvalid[grant] may drop mid-packet; the FSM stays in BUSY and the grant is held until tlast.
REQ-017 Arbitration order is selected by the Configuration macro (REQ-021).
REQ-018 Requests from non-granted streams are never lost: their s_tready stays 0 and the source holds its data per AXI-Stream rules.

Reset
REQ-019 While aresetn=0, outputs are forced to: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0; FSM=IDLE; grant=0; round-robin pointer=0.
REQ-020 Reset asserted mid-packet discards the packet in flight without completing it; the first edge after deassertion is a normal IDLE arbitration cycle.

Configuration
REQ-021 Macro AXIS_PKT_MUX_ROUND_ROBIN_EN:
- Defined: round-robin arbitration. Search starts at pointer p and picks the first requesting index in p, p+1, ... wrapping modulo NUM_STREAMS. On tlast acceptance, p is set to (grant+1) mod NUM_STREAMS; the wrap from NUM_STREAMS-1 to 0 is required.
- Undefined: fixed priority. The lowest requesting index wins and the pointer logic is absent.

Verification
REQ-022 NUM_STREAMS=2, DATA_WIDTH=8; stream 0 sends a 3-beat packet 0x11,0x22,0x33 (tlast on 0x33), m_tready=1 -> m_tvalid rises 2 cycles after s_tvalid[0], beats appear on consecutive cycles, m_tid=0, m_tlast only on 0x33.
REQ-023 Streams 0 and 1 both hold 2-beat packets continuously, round-robin defined -> output m_tid sequence is 0,0,1,1,0,0, with exactly one bubble cycle between packets. With the macro undefined, the sequence is 0,0,0,0 (stream 1 starved).
REQ-024 Stream 1 granted; m_tready held low for 3 cycles mid-packet -> m_tdata, m_tid and m_tlast stay stable, s_tready[1]=0 during the stall, and no beat is duplicated or dropped.
REQ-025 NUM_STREAMS=4, round-robin; stream 3 completes a packet, then streams 0 and 2 request -> the next grant goes to stream 0 (pointer wrap 3->0).
REQ-026 aresetn pulsed low during beat 2 of a 4-beat packet -> all outputs read 0 during reset; after release, a new packet from stream 1 is arbitrated normally with m_tid=1.
